// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: request, adder-side and result signals of the nibble sequencer
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [3:0]   add_r1;
    logic [3:0]   add_r2;
    logic         add_ci;
    logic [3:0]   add_result;
    logic         add_carry;
    logic [W-1:0] sum;
    logic         cout;
    logic         done;
    logic         busy;

    // Requester plus the external 4-bit adder: drives operands and adder results.
    modport master (
        output start_valid, a, b, cin, add_result, add_carry,
        input  start_ready, add_r1, add_r2, add_ci, sum, cout, done, busy
    );

    // The sequencer itself.
    modport slave (
        input  start_valid, a, b, cin, add_result, add_carry,
        output start_ready, add_r1, add_r2, add_ci, sum, cout, done, busy
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: feeds wide operands to a 4-bit adder one nibble per clock and assembles the sum
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_adder_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_next;
    logic [W-1:0]  sum_q;
    logic          carry_q;
    logic          cout_q;
    logic          last;

    assign last = idx == IW'(NIBBLES - 1);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state: accept only in IDLE, leave RUN after the top nibble, DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = bus.start_valid ? RUN : IDLE;
            RUN:     state_next = last ? DONE : RUN;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: adder inputs are only live in RUN so the adder sees zeros otherwise.
    always_comb begin
        bus.start_ready = state == IDLE;
        bus.busy        = state != IDLE;
        bus.done        = state == DONE;
        bus.add_r1      = state == RUN ? a_q[3:0] : 4'd0;
        bus.add_r2      = state == RUN ? b_q[3:0] : 4'd0;
        bus.add_ci      = state == RUN ? carry_q : 1'b0;
        bus.sum         = sum_q;
        bus.cout        = cout_q;
    end

    // Accumulator with the current adder nibble merged in, so the last edge can publish it whole.
    always_comb begin
        acc_next = acc;
        acc_next[4*idx +: 4] = bus.add_result;
    end

    // Datapath: latch on acceptance, shift operands and chain the carry while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (state == IDLE && bus.start_valid) begin
            idx     <= '0;
            a_q     <= bus.a;
            b_q     <= bus.b;
            acc     <= '0;
            carry_q <= bus.cin;
        end else if (state == RUN) begin
            idx     <= idx + IW'(1);
            a_q     <= a_q >> 4;
            b_q     <= b_q >> 4;
            acc     <= acc_next;
            carry_q <= bus.add_carry;
            if (last) begin
                sum_q  <= acc_next;
                cout_q <= bus.add_carry;
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed vectors against a behavioural 4-bit adder attached to the sequencer
module tb_nibble_serial_adder;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.NIBBLES(NIBBLES)) bus();

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // External 4-bit ripple adder stand-in: combinational, same cycle.
    assign {bus.add_carry, bus.add_result} = {1'b0, bus.add_r1} + {1'b0, bus.add_r2} + {4'd0, bus.add_ci};

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic [3:0]   ci;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] held_sum = '0;
    vec_t         vecs[6];
    vec_t         v;
    logic [W:0]   exp_q[$];
    logic [W:0]   e;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " sum"}, 32'(bus.sum), 32'h0);
        chk({tag, " cout"}, 32'(bus.cout), 32'h0);
        chk({tag, " done"}, 32'(bus.done), 32'h0);
        chk({tag, " busy"}, 32'(bus.busy), 32'h0);
        chk({tag, " ready"}, 32'(bus.start_ready), 32'h1);
        chk({tag, " add_bus"}, {23'd0, bus.add_r1, bus.add_r2, bus.add_ci}, 32'h0);
    endtask

    // One full operation: accept at E0, observe each RUN nibble, done between E4 and E5.
    task automatic run_vec(input vec_t t, input string tag);
        @(negedge clk);
        chk({tag, " ready before"}, 32'(bus.start_ready), 32'h1);
        bus.start_valid = 1'b1;
        bus.a = t.a;
        bus.b = t.b;
        bus.cin = t.cin;
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.a = ~t.a;
        bus.b = ~t.b;
        bus.cin = ~t.cin;
        for (int k = 0; k < NIBBLES; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("%s ci%0d", tag, k), 32'(bus.add_ci), 32'(t.ci[k]));
            chk($sformatf("%s done low %0d", tag, k), 32'(bus.done), 32'h0);
            chk($sformatf("%s sum held %0d", tag, k), 32'(bus.sum), 32'(held_sum));
        end
        @(negedge clk);
        chk({tag, " done high"}, 32'(bus.done), 32'h1);
        chk({tag, " sum"}, 32'(bus.sum), 32'(t.sum));
        chk({tag, " cout"}, 32'(bus.cout), 32'(t.cout));
        held_sum = t.sum;
        @(negedge clk);
        chk({tag, " done after"}, 32'(bus.done), 32'h0);
        chk({tag, " ready after"}, 32'(bus.start_ready), 32'h1);
        chk({tag, " sum kept"}, 32'(bus.sum), 32'(t.sum));
    endtask

    initial begin
        vecs[0] = '{a: 16'h1234, b: 16'h1111, cin: 1'b0, sum: 16'h2345, cout: 1'b0, ci: 4'b0000};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1, ci: 4'b1110};
        vecs[2] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, cout: 1'b1, ci: 4'b1111};
        vecs[3] = '{a: 16'h0000, b: 16'h0000, cin: 1'b0, sum: 16'h0000, cout: 1'b0, ci: 4'b0000};
        vecs[4] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1, ci: 4'b0000};
        vecs[5] = '{a: 16'hABCD, b: 16'h1234, cin: 1'b1, sum: 16'hBE02, cout: 1'b0, ci: 4'b0111};

        bus.start_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;

        #2;
        chk_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back requests with operands changing every cycle.
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            chk($sformatf("pipe ready c%0d", c), 32'(bus.start_ready), 32'((c % 6) == 0));
            chk($sformatf("pipe done c%0d", c), 32'(bus.done), 32'((c % 6) == 5));
            if (bus.done && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("pipe sum c%0d", c), 32'(bus.sum), 32'(e[W-1:0]));
                chk($sformatf("pipe cout c%0d", c), 32'(bus.cout), 32'(e[W]));
                held_sum = e[W-1:0];
            end
            bus.start_valid = 1'b1;
            bus.a = 16'(c * 16'h0F1D + 16'h3007);
            bus.b = 16'((c * 16'h1357) ^ 16'hA5A5);
            bus.cin = c[0];
            if ((c % 6) == 0)
                exp_q.push_back({1'b0, bus.a} + {1'b0, bus.b} + {16'd0, bus.cin});
        end
        bus.start_valid = 1'b0;
        chk("pipe results drained", 32'(exp_q.size()), 32'h0);

        // Abort mid-operation with an asynchronous reset between edges.
        @(negedge clk);
        @(negedge clk);
        chk("pre-abort sum nonzero", 32'(bus.sum != 0), 32'h1);
        bus.start_valid = 1'b1;
        bus.a = 16'h00FF;
        bus.b = 16'h0001;
        bus.cin = 1'b0;
        @(negedge clk);
        bus.start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort busy", 32'(bus.busy), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk_reset_outputs("abort");
        #1 rst = 1'b0;
        held_sum = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("abort no done %0d", k), 32'(bus.done), 32'h0);
            chk($sformatf("abort sum %0d", k), 32'(bus.sum), 32'h0);
        end
        v = '{a: 16'h0001, b: 16'h0001, cin: 1'b0, sum: 16'h0002, cout: 1'b0, ci: 4'b0000};
        run_vec(v, "post-abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
